// File: rtl/mux_nway_stream_pkg.sv
// mux_nway_stream_pkg: selection mode encodings and index helpers shared by the stream mux
package mux_nway_stream_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    function automatic int wrap_inc(input int i, input int n);
        return (i + 1) % n;
    endfunction

endpackage

// File: rtl/mux_nway_stream_rr.sv
// rr_arbiter: combinational round-robin search for the first requester at or after ptr
module rr_arbiter
    import mux_nway_stream_pkg::*;
#(
    parameter int NWAY = 8,
    parameter int SELW = $clog2(NWAY)
) (
    input  logic [NWAY-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            grant_valid
);

    logic [SELW-1:0] cand [NWAY];

    for (genvar c = 0; c < NWAY; c++) begin : g_cand
        assign cand[c] = SELW'((int'(ptr) + c) % NWAY);
    end

    // Scanning from the far end lets the nearest requester overwrite the rest.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = NWAY - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                grant       = cand[k];
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nway_stream.sv
// mux_nway_stream: N-way valid/ready mux with explicit or round-robin select and one registered output stage
module mux_nway_stream
    import mux_nway_stream_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NWAY  = 8,
    parameter int SELW  = $clog2(NWAY)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    input  logic [NWAY*WIDTH-1:0] in_data,
    input  logic [NWAY-1:0]       in_valid,
    output logic [NWAY-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_chan,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int NPAD = 1 << SELW;

    logic [WIDTH-1:0] chan [NWAY];
    logic [NPAD-1:0]  valid_pad;
    logic [SELW-1:0]  rr_ptr, arb_grant, grant;
    logic             arb_valid, grant_valid, can_load, take;

    for (genvar c = 0; c < NWAY; c++) begin : g_chan
        assign chan[c] = in_data[c*WIDTH +: WIDTH];
    end

    // Zero padding makes any sel beyond NWAY-1 read as "not valid".
    assign valid_pad = NPAD'(in_valid);

    rr_arbiter #(.NWAY(NWAY)) u_arb (
        .req        (in_valid),
        .ptr        (rr_ptr),
        .grant      (arb_grant),
        .grant_valid(arb_valid)
    );

    always_comb begin
        can_load    = !out_valid || out_ready;
        grant       = mode == MODE_RR ? arb_grant : sel;
        grant_valid = mode == MODE_RR ? arb_valid : valid_pad[sel];
        take        = rst_n && can_load && grant_valid;
        in_ready    = take ? NWAY'(1) << grant : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= chan[grant];
            out_chan  <= grant;
            if (mode == MODE_RR) rr_ptr <= SELW'(wrap_inc(int'(grant), NWAY));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nway_stream.sv
// tb_mux_nway_stream: directed and randomized checks of the stream mux against a behavioural model
module tb_mux_nway_stream;

    logic         clk = 1'b0;
    logic         rst_n, mode, out_ready, out_valid;
    logic [2:0]   sel, out_chan;
    logic [15:0]  dat [8];
    logic [127:0] in_data;
    logic [7:0]   in_valid, in_ready;
    logic [15:0]  out_data;

    logic         mode6, out_ready6, out_valid6;
    logic [2:0]   sel6, out_chan6;
    logic [95:0]  in_data6;
    logic [5:0]   in_valid6, in_ready6;
    logic [15:0]  out_data6;

    int n_cmp = 0, n_err = 0;
    bit          m_valid;
    logic [15:0] m_data;
    int          m_chan, m_ptr, g;
    logic [7:0]  er;
    int          seq [6] = '{0, 2, 7, 0, 2, 7};
    logic [15:0] held;

    always #5 clk = ~clk;

    always_comb for (int i = 0; i < 8; i++) in_data[i*16 +: 16] = dat[i];

    mux_nway_stream #(.WIDTH(16), .NWAY(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_nway_stream #(.WIDTH(16), .NWAY(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .mode(mode6), .sel(sel6),
        .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
        .out_data(out_data6), .out_chan(out_chan6), .out_valid(out_valid6), .out_ready(out_ready6)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Which channel the rules say should win this cycle, or -1.
    function automatic int find_grant();
        if (!mode) return in_valid[sel] ? int'(sel) : -1;
        for (int k = 0; k < 8; k++)
            if (in_valid[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
        return -1;
    endfunction

    task automatic tick();
        #1;
        g  = (rst_n && (!m_valid || out_ready)) ? find_grant() : -1;
        er = g < 0 ? 8'h00 : 8'(1 << g);
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("w6_in_ready", 32'(in_ready6), 0);
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_valid = 1; m_data = dat[g]; m_chan = g;
            if (mode) m_ptr = (g + 1) % 8;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_chan", 32'(out_chan), m_chan);
        chk("w6_out_valid", 32'(out_valid6), 0);
    endtask

    initial begin
        m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0;
        for (int i = 0; i < 8; i++) dat[i] = 16'($urandom);
        mode6 = 1'b0; sel6 = 3'd7; in_valid6 = 6'h3F; out_ready6 = 1'b1; in_data6 = {$urandom, $urandom, $urandom};
        rst_n = 1'b0; mode = 1'b0; sel = 3'd0; in_valid = 8'hFF; out_ready = 1'b1;
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);

        rst_n = 1'b1; sel = 3'd3; dat[3] = 16'hBEEF;
        #1 chk("sel_in_ready", 32'(in_ready), 32'h08);
        tick();
        chk("sel_data", 32'(out_data), 32'hBEEF);
        chk("sel_chan", 32'(out_chan), 3);
        chk("sel_valid", 32'(out_valid), 1);

        mode = 1'b1; in_valid = 8'b1000_0101;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_seq", 32'(out_chan), seq[i]);
        end
        tick(); tick();
        chk("bp_pre_chan", 32'(out_chan), 2);
        held = out_data;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dat[2] = 16'($urandom);
            tick();
            chk("bp_hold", 32'(out_data), 32'(held));
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_chan", 32'(out_chan), 7);
        chk("bp_release_valid", 32'(out_valid), 1);

        in_valid = 8'hFF;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 0);
        rst_n = 1'b1;
        tick();
        chk("mid_rst_chan", 32'(out_chan), 0);

        for (int n = 0; n < 2000; n++) begin
            rst_n     = $urandom_range(0, 99) != 0;
            mode      = 1'($urandom);
            sel       = 3'($urandom);
            in_valid  = 8'($urandom) & 8'($urandom | $urandom);
            out_ready = $urandom_range(0, 3) != 0;
            for (int i = 0; i < 8; i++) dat[i] = 16'($urandom);
            tick();
        end

        chk("w6_final_valid", 32'(out_valid6), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_nway_stream.md
Name: mux_nway_stream

Overview:
- Parametrised successor of the 8-way 16-bit combinational mux.
- Selects one of NWAY valid/ready input channels of WIDTH bits and drives a single registered output channel.
- Two selection modes: explicit select, or round-robin fair arbitration.
- Sits between multiple Hack producers (e.g. register-file read ports, I/O sources) and a single consumer; provides back-pressure and exactly one cycle of latency.

Parameters:
- WIDTH, 16, data width per channel (>=1).
- NWAY, 8, number of input channels (2..32; need not be a power of 2).
- SELW, $clog2(NWAY), select/channel-index width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- mode  input  1  0 = explicit select via sel; 1 = round-robin.
- sel  input  SELW  channel index used when mode=0.
- in_data  input  NWAY*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NWAY  per-channel valid.
- in_ready  output  NWAY  per-channel ready; one-hot or zero.
- out_data  output  WIDTH  registered selected data.
- out_chan  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  output holds a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_chan=0, rr_ptr=0. in_ready is combinationally 0 while rst_n=0.
- can_load = !out_valid || out_ready.
- Grant, mode=0: grant=sel if sel<NWAY and in_valid[sel]; otherwise no grant. sel>=NWAY never grants.
- Grant, mode=1: first i with in_valid[i]=1, scanning from rr_ptr upward and wrapping NWAY-1 -> 0. No grant if in_valid is all zero.
- in_ready[g]=1 only when can_load and grant g exists; all other bits are 0.
- Transfer: at a clk edge with in_valid[g] && in_ready[g], load out_data=in_data[g] and out_chan=g, and set out_valid=1. Latency from input handshake to out_valid is 1 cycle.
- Output consumed (out_valid && out_ready) with no new transfer: out_valid=0. out_data and out_chan keep their last values.
- Simultaneous consume and transfer in the same cycle: new word loaded and out_valid stays 1. This gives full throughput of 1 word/cycle.
- Stall (out_valid && !out_ready): out_data, out_chan and out_valid hold stable. All in_ready=0.
- rr_ptr: updates only on a transfer while mode=1, to (g+1) mod NWAY. Wrap-around from NWAY-1 goes to 0. rr_ptr is unchanged while mode=0.
- Changes to mode or sel during a stall do not affect the held output. They apply to the next grant only.
- Reset mid-operation discards any held word: out_valid=0 on the next edge.
- No combinational path from out_ready to out_data. The path from out_ready to in_ready is allowed.

Decomposition:
- Shared package/header holds localparam MODE_SEL=1'b0 and MODE_RR=1'b1.
- Sub-module rr_arbiter (parameter NWAY): combinational priority search from rr_ptr. Outputs grant index and grant_valid; reused in mode=1.
- Top level holds the output register, rr_ptr and mode=0 select logic.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=16'h0000 after release edge.
- Explicit select: mode=0, sel=3, in_data[3]=16'hBEEF, in_valid=8'hFF, out_ready=1 -> in_ready=8'h08 on the same cycle; out_data=16'hBEEF, out_chan=3, out_valid=1 one cycle later.
- Round-robin fairness: mode=1, in_valid=8'b1000_0101 held, out_ready=1 -> out_chan sequence 0,2,7,0,2,7, one word per cycle. Confirms wrap from 7 to 0.
- Back-pressure: out_valid=1 with out_chan=2, out_ready=0 for 3 cycles while in_data[2] changes -> out_data stable, in_ready=0. Then out_ready=1 -> next channel (7) loads on the following edge with no bubble.
- Invalid select: NWAY=6 instance, mode=0, sel=7, in_valid=6'h3F -> in_ready=0 and out_valid stays 0 indefinitely.
- Reset mid-stream: mode=1 streaming, assert rst_n=0 for 1 cycle while out_valid=1 -> out_valid=0. After release the next grant starts at channel 0 (rr_ptr=0).
